// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer types, response codes,
// default-slave FSM states and the default decode map.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      DS_IDLE = 2'b00,
      DS_ERR1 = 2'b01,
      DS_ERR2 = 2'b10
   } dflt_state_t;

   // Default map for up to 32 slaves: slave i answers at HADDR[31:16] = 0x4000 + i.
   function automatic logic [511:0] default_base_map();
      logic [511:0] map;
      map = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         map[16*i +: 16] = 16'h4000 + 16'(i);
      end
      return map;
   endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in AHB default slave: answers unmapped NONSEQ/SEQ transfers with the
// two-cycle ERROR response. Optional error log under AHB_DEC_ERR_LOG_EN.
module ahb_default_slave
   import ahb_pkg::*;
(
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        hready,
   input  logic        dflt_sel,
   input  logic [1:0]  htrans,
`ifdef AHB_DEC_ERR_LOG_EN
   input  logic [31:0] haddr,
   output logic [15:0] err_cnt,
   output logic [31:0] err_addr,
`endif
   output logic        dflt_ready,
   output logic        dflt_resp
);

   dflt_state_t state;
   dflt_state_t state_nxt;
   logic        accept_err;

   assign accept_err = hready && dflt_sel &&
                       ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

   // State register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state <= DS_IDLE;
      else          state <= state_nxt;
   end

   // Next state and default-slave response
   always_comb begin
      state_nxt  = state;
      dflt_ready = 1'b1;
      dflt_resp  = HRESP_OKAY;
      case (state)
         DS_IDLE: begin
            if (accept_err) state_nxt = DS_ERR1;
         end
         DS_ERR1: begin
            dflt_ready = 1'b0;
            dflt_resp  = HRESP_ERROR;
            state_nxt  = DS_ERR2;
         end
         DS_ERR2: begin
            dflt_resp = HRESP_ERROR;
            state_nxt = accept_err ? DS_ERR1 : DS_IDLE;
         end
         default: state_nxt = DS_IDLE;
      endcase
   end

`ifdef AHB_DEC_ERR_LOG_EN
   logic err_evt;

   // ERR1 is entered only from IDLE or ERR2, so any accepted error outside ERR1 is an entry
   assign err_evt = accept_err && (state != DS_ERR1);

   // Saturating error counter and last-error address capture
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         err_cnt  <= '0;
         err_addr <= '0;
      end else if (err_evt) begin
         if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
         err_addr <= haddr;
      end
   end
`endif

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder and slave response multiplexer with built-in
// default slave. Optional error log enabled by defining AHB_DEC_ERR_LOG_EN.
module ahb_decoder_mux
   import ahb_pkg::*;
#(
   parameter int                 DLY      = 1,
   parameter int unsigned        NSLV     = 12,
   parameter logic [NSLV*16-1:0] SLV_BASE = (NSLV*16)'(default_base_map()),
   parameter logic [NSLV*16-1:0] SLV_MASK = {NSLV{16'hFFFF}}
)
(
   input  logic               HCLK,
   input  logic               HRESETn,
   input  logic [31:0]        HADDR,
   input  logic [1:0]         HTRANS,
   input  logic [NSLV-1:0]    HREADYOUTS,
   input  logic [NSLV-1:0]    HRESPS,
   input  logic [NSLV*32-1:0] HRDATAS,
   output logic [NSLV-1:0]    HSELS,
   output logic               HREADY,
   output logic               HRESP,
   output logic [31:0]        HRDATA
`ifdef AHB_DEC_ERR_LOG_EN
   ,
   output logic [15:0]        dec_err_cnt,
   output logic [31:0]        dec_err_addr
`endif
);

   // DLY is kept so existing instantiations still elaborate; register updates carry no delay.
   if (NSLV < 1 || NSLV > 32 || DLY < 0) begin : g_param_check
      $error("ahb_decoder_mux: NSLV must be 1..32 and DLY non-negative");
   end

   logic [NSLV:0] sel_d;
   logic          dflt_sel;
   logic          dflt_ready;
   logic          dflt_resp;

   // Address decode: first matching region in index order wins
   always_comb begin : p_decode
      logic taken;
      taken = 1'b0;
      HSELS = '0;
      for (int unsigned i = 0; i < NSLV; i++) begin
         if (!taken && (((HADDR[31:16] ^ SLV_BASE[16*i +: 16]) & SLV_MASK[16*i +: 16]) == 16'h0)) begin
            HSELS[i] = 1'b1;
            taken    = 1'b1;
         end
      end
   end

   assign dflt_sel = ~|HSELS;

   // Data-phase select, advanced only when the bus is ready
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)    sel_d <= '0;
      else if (HREADY) sel_d <= {dflt_sel, HSELS};
   end

   // Response mux: selected slave, else default slave (also covers sel_d == 0)
   always_comb begin
      HRDATA = '0;
      HREADY = dflt_ready;
      HRESP  = dflt_resp;
      if (!sel_d[NSLV]) begin
         for (int unsigned i = 0; i < NSLV; i++) begin
            if (sel_d[i]) begin
               HRDATA = HRDATAS[32*i +: 32];
               HREADY = HREADYOUTS[i];
               HRESP  = HRESPS[i];
            end
         end
      end
   end

   ahb_default_slave u_dflt (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .hready     (HREADY),
      .dflt_sel   (dflt_sel),
      .htrans     (HTRANS),
`ifdef AHB_DEC_ERR_LOG_EN
      .haddr      (HADDR),
      .err_cnt    (dec_err_cnt),
      .err_addr   (dec_err_addr),
`endif
      .dflt_ready (dflt_ready),
      .dflt_resp  (dflt_resp)
   );

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed self-checking bench for ahb_decoder_mux.
module tb_ahb_decoder_mux;

  localparam int unsigned NSLV = 12;
  localparam logic [NSLV*16-1:0] BASE_MAP = {16'h7123, 16'h7000, 16'h4005, 16'h4004,
                                             16'h3007, 16'h3006, 16'h3005, 16'h3004,
                                             16'h3003, 16'h3002, 16'h3001, 16'h3000};
  localparam logic [NSLV*16-1:0] MASK_MAP = {16'hFFFF, 16'hF000, {10{16'hFFFF}}};

  logic               HCLK = 1'b0;
  logic               HRESETn;
  logic [31:0]        HADDR;
  logic [1:0]         HTRANS;
  logic [NSLV-1:0]    HREADYOUTS;
  logic [NSLV-1:0]    HRESPS;
  logic [NSLV*32-1:0] HRDATAS;
  logic [NSLV-1:0]    HSELS;
  logic               HREADY;
  logic               HRESP;
  logic [31:0]        HRDATA;
`ifdef AHB_DEC_ERR_LOG_EN
  logic [15:0]        dec_err_cnt;
  logic [31:0]        dec_err_addr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 HCLK = ~HCLK;

  ahb_decoder_mux #(
    .DLY      (1),
    .NSLV     (NSLV),
    .SLV_BASE (BASE_MAP),
    .SLV_MASK (MASK_MAP)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HREADYOUTS (HREADYOUTS),
    .HRESPS     (HRESPS),
    .HRDATAS    (HRDATAS),
    .HSELS      (HSELS),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA)
`ifdef AHB_DEC_ERR_LOG_EN
    ,
    .dec_err_cnt  (dec_err_cnt),
    .dec_err_addr (dec_err_addr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn    = 1'b0;
    HADDR      = 32'h0;
    HTRANS     = 2'b00;
    HREADYOUTS = '1;
    HRESPS     = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      HRDATAS[32*i +: 32] = {16'h1010, 16'(i)};
    end
    HRDATAS[32*8 +: 32] = 32'hA5A5_0001;
    HRDATAS[32*9 +: 32] = 32'hA5A5_0002;

    // Reset state
    repeat (3) next_cycle();
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("rst_hready", HREADY, 1'b1);
    check("rst_hresp",  HRESP,  1'b0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_sel_d",  dut.sel_d, 13'h0);
`ifdef AHB_DEC_ERR_LOG_EN
    check("rst_err_cnt", dec_err_cnt, 16'h0);
`endif

    // Mapped read to slave 8, no wait state
    next_cycle();
    HADDR  = 32'h4004_0010;
    HTRANS = 2'b10;
    @(negedge HCLK);
    check("dec_slave8", HSELS, 12'h100);
    next_cycle();
    HADDR  = 32'h0;
    HTRANS = 2'b00;
    @(negedge HCLK);
    check("s8_sel_d",   dut.sel_d, 13'h0100);
    check("s8_hrdata",  HRDATA, 32'hA5A5_0001);
    check("s8_hready",  HREADY, 1'b1);
    check("s8_hresp",   HRESP,  1'b0);
    HRESPS[8] = 1'b1;
    #1;
    check("s8_resp_pass", HRESP, 1'b1);
    HRESPS[8] = 1'b0;

    // Slave 9 inserts three wait states; next address phase held
    next_cycle();
    HADDR  = 32'h4005_0000;
    HTRANS = 2'b10;
    @(negedge HCLK);
    check("dec_slave9", HSELS, 12'h200);
    next_cycle();
    HREADYOUTS[9] = 1'b0;
    HADDR  = 32'h4004_0000;
    HTRANS = 2'b10;
    @(negedge HCLK);
    check("s9_wait1_hready", HREADY, 1'b0);
    next_cycle();
    @(negedge HCLK);
    check("s9_wait2_hready", HREADY, 1'b0);
    check("s9_wait2_sel_d",  dut.sel_d, 13'h0200);
    next_cycle();
    @(negedge HCLK);
    check("s9_wait3_hready", HREADY, 1'b0);
    check("s9_wait3_sel_d",  dut.sel_d, 13'h0200);
    next_cycle();
    HREADYOUTS[9] = 1'b1;
    @(negedge HCLK);
    check("s9_done_hready", HREADY, 1'b1);
    check("s9_done_hrdata", HRDATA, 32'hA5A5_0002);
    next_cycle();
    HADDR  = 32'h0;
    HTRANS = 2'b00;
    @(negedge HCLK);
    check("held_addr_sel_d", dut.sel_d, 13'h0100);
    check("held_addr_hrdata", HRDATA, 32'hA5A5_0001);

    // Back-to-back unmapped NONSEQ: ERR1, ERR2, ERR1, ERR2
    next_cycle();
    HADDR  = 32'h5000_0000;
    HTRANS = 2'b10;
    @(negedge HCLK);
    check("dec_unmapped", HSELS, 12'h000);
    next_cycle();
    HADDR  = 32'h6000_0004;
    HTRANS = 2'b10;
    @(negedge HCLK);
    check("err1a_hready", HREADY, 1'b0);
    check("err1a_hresp",  HRESP,  1'b1);
    check("err1a_hrdata", HRDATA, 32'h0);
    next_cycle();
    @(negedge HCLK);
    check("err2a_hready", HREADY, 1'b1);
    check("err2a_hresp",  HRESP,  1'b1);
    next_cycle();
    HADDR  = 32'h5000_0000;
    HTRANS = 2'b00;
    @(negedge HCLK);
    check("err1b_hready", HREADY, 1'b0);
    check("err1b_hresp",  HRESP,  1'b1);
    next_cycle();
    @(negedge HCLK);
    check("err2b_hready", HREADY, 1'b1);
    check("err2b_hresp",  HRESP,  1'b1);

    // IDLE transfer to unmapped address: zero-wait OKAY
    next_cycle();
    @(negedge HCLK);
    check("idle_unmapped_hready", HREADY, 1'b1);
    check("idle_unmapped_hresp",  HRESP,  1'b0);
    next_cycle();
    @(negedge HCLK);
    check("idle_unmapped2_hready", HREADY, 1'b1);
    check("idle_unmapped2_hresp",  HRESP,  1'b0);
`ifdef AHB_DEC_ERR_LOG_EN
    check("log_err_cnt",  dec_err_cnt,  16'd2);
    check("log_err_addr", dec_err_addr, 32'h6000_0004);
`endif

    // Overlap and region boundary decode
    HADDR = 32'h7123_0000;
    #1;
    check("dec_overlap_low_wins", HSELS, 12'h400);
    HADDR = 32'h7FFF_FFFF;
    #1;
    check("dec_masked_region", HSELS, 12'h400);
    HADDR = 32'h3000_0000;
    #1;
    check("dec_slave0", HSELS, 12'h001);
    HADDR = 32'h3007_FFFF;
    #1;
    check("dec_slave7_top", HSELS, 12'h080);
    HADDR = 32'h3008_0000;
    #1;
    check("dec_gap", HSELS, 12'h000);

    // Reset asserted in the middle of ERR1
    next_cycle();
    HADDR  = 32'h5000_0000;
    HTRANS = 2'b10;
    next_cycle();
    HADDR  = 32'h0;
    HTRANS = 2'b00;
    @(negedge HCLK);
    check("pre_rst_err1_hready", HREADY, 1'b0);
    #2;
    HRESETn = 1'b0;
    #1;
    check("mid_rst_hready", HREADY, 1'b1);
    check("mid_rst_hresp",  HRESP,  1'b0);
    check("mid_rst_hrdata", HRDATA, 32'h0);
    check("mid_rst_sel_d",  dut.sel_d, 13'h0);
`ifdef AHB_DEC_ERR_LOG_EN
    check("mid_rst_err_cnt", dec_err_cnt, 16'h0);
`endif
    next_cycle();
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("post_rst_hready", HREADY, 1'b1);
    check("post_rst_hresp",  HRESP,  1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
